// File: rtl/mandelbrot_frame_scheduler.sv
// Purpose: sweeps one Mandelbrot frame, dispatching pixels to NUM_ENGINES iterators and writing tagged results.
// Latency: dispatch pulse/operands registered one cycle after slot seen FREE; write presented one cycle after READY.
// Backpressure: wr_ready low holds the presented write and stalls collection; dispatch stops once no slot is FREE.
module mandelbrot_frame_scheduler #(
   parameter int NUM_ENGINES = 4,
   parameter int X_RES       = 640,
   parameter int Y_RES       = 480,
   parameter int ADDR_W      = 19
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [26:0]                cr_start,
   input  logic [26:0]                ci_start,
   input  logic [26:0]                dx,
   input  logic [26:0]                dy,
   input  logic [15:0]                max_iterations,
   output logic [NUM_ENGINES-1:0]     eng_start,
   output logic [27*NUM_ENGINES-1:0]  eng_cr,
   output logic [27*NUM_ENGINES-1:0]  eng_ci,
   output logic [15:0]                eng_max_iter,
   input  logic [NUM_ENGINES-1:0]     eng_done,
   input  logic [16*NUM_ENGINES-1:0]  eng_iterations,
   output logic                       wr_valid,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [15:0]                wr_data,
   input  logic                       wr_ready,
   output logic                       busy,
   output logic                       frame_done,
   output logic [31:0]                frame_cycles
);

   localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam int X_W   = (X_RES > 1) ? $clog2(X_RES) : 1;
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(X_RES * Y_RES - 1);
   localparam logic [X_W-1:0]    LAST_X   = X_W'(X_RES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   typedef enum logic [1:0] {FREE, BUSY, READY} slot_t;

   state_t                     state_q;
   slot_t                      slot_q [NUM_ENGINES];
   logic [ADDR_W-1:0]          tag_q  [NUM_ENGINES];
   logic [26:0]                cr0_q, dx_q, dy_q, cur_cr_q, cur_ci_q;
   logic [X_W-1:0]             x_q;
   logic [ADDR_W-1:0]          pix_q;
   logic [NUM_ENGINES-1:0]     eng_start_q;
   logic [27*NUM_ENGINES-1:0]  eng_cr_q, eng_ci_q;
   logic [15:0]                max_iter_q;
   logic                       wr_valid_q;
   logic [ADDR_W-1:0]          wr_addr_q;
   logic [15:0]                wr_data_q;
   logic [IDX_W-1:0]           wr_slot_q, rr_q;
   logic                       busy_q, done_q;
   logic [31:0]                cyc_q, last_q, frame_cycles_q;

   logic                       disp_vld_d, grant_vld_d, all_free_d, wr_accept_d;
   logic [IDX_W-1:0]           disp_idx_d, grant_idx_d;
   int                         cand;

   // Pick the lowest FREE slot for dispatch and the next READY slot (round robin) for the write port.
   always_comb begin
      disp_vld_d  = 1'b0;
      disp_idx_d  = '0;
      all_free_d  = 1'b1;
      grant_vld_d = 1'b0;
      grant_idx_d = '0;
      cand        = 0;
      wr_accept_d = wr_valid_q && wr_ready;
      for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
         if (slot_q[k] == FREE) begin
            disp_vld_d = 1'b1;
            disp_idx_d = IDX_W'(k);
         end else begin
            all_free_d = 1'b0;
         end
      end
      if (state_q != RUN) disp_vld_d = 1'b0;
      // the slot currently on the port is still READY; skip it while its write completes
      if (!wr_valid_q || wr_ready) begin
         for (int i = 1; i <= NUM_ENGINES; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_ENGINES) cand = cand - NUM_ENGINES;
            if (!grant_vld_d && slot_q[IDX_W'(cand)] == READY &&
                !(wr_valid_q && wr_slot_q == IDX_W'(cand))) begin
               grant_vld_d = 1'b1;
               grant_idx_d = IDX_W'(cand);
            end
         end
      end
   end

   // Frame FSM, slot bookkeeping, coordinate sweep and write port, all registered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         cr0_q          <= '0;
         dx_q           <= '0;
         dy_q           <= '0;
         cur_cr_q       <= '0;
         cur_ci_q       <= '0;
         x_q            <= '0;
         pix_q          <= '0;
         eng_start_q    <= '0;
         eng_cr_q       <= '0;
         eng_ci_q       <= '0;
         max_iter_q     <= '0;
         wr_valid_q     <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         wr_slot_q      <= '0;
         rr_q           <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         cyc_q          <= '0;
         last_q         <= '0;
         frame_cycles_q <= '0;
         for (int k = 0; k < NUM_ENGINES; k++) begin
            slot_q[k] <= FREE;
            tag_q[k]  <= '0;
         end
      end else begin
         eng_start_q <= '0;
         done_q      <= 1'b0;
         // done is stale during the launch cycle, so only trust it once the pulse has gone
         for (int k = 0; k < NUM_ENGINES; k++) begin
            if (slot_q[k] == BUSY && eng_done[k] && !eng_start_q[k]) slot_q[k] <= READY;
         end
         if (wr_accept_d) begin
            slot_q[wr_slot_q] <= FREE;
            wr_valid_q        <= 1'b0;
            last_q            <= cyc_q + 32'd1;
         end
         if (grant_vld_d) begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= tag_q[grant_idx_d];
            wr_data_q  <= eng_iterations[16*grant_idx_d +: 16];
            wr_slot_q  <= grant_idx_d;
            rr_q       <= grant_idx_d;
         end
         if (disp_vld_d) begin
            slot_q[disp_idx_d]               <= BUSY;
            tag_q[disp_idx_d]                <= pix_q;
            eng_start_q[disp_idx_d]          <= 1'b1;
            eng_cr_q[27*disp_idx_d +: 27]    <= cur_cr_q;
            eng_ci_q[27*disp_idx_d +: 27]    <= cur_ci_q;
            pix_q                            <= pix_q + 1'b1;
            if (x_q == LAST_X) begin
               x_q      <= '0;
               cur_cr_q <= cr0_q;
               cur_ci_q <= cur_ci_q - dy_q;
            end else begin
               x_q      <= x_q + 1'b1;
               cur_cr_q <= cur_cr_q + dx_q;
            end
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= RUN;
                  busy_q     <= 1'b1;
                  cr0_q      <= cr_start;
                  dx_q       <= dx;
                  dy_q       <= dy;
                  max_iter_q <= max_iterations;
                  cur_cr_q   <= cr_start;
                  cur_ci_q   <= ci_start;
                  x_q        <= '0;
                  pix_q      <= '0;
                  cyc_q      <= 32'd1;
                  last_q     <= '0;
               end
            end
            RUN: begin
               cyc_q <= cyc_q + 32'd1;
               if (disp_vld_d && pix_q == LAST_PIX) state_q <= DRAIN;
            end
            DRAIN: begin
               cyc_q <= cyc_q + 32'd1;
               if (all_free_d) begin
                  state_q        <= DONE;
                  done_q         <= 1'b1;
                  frame_cycles_q <= last_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign eng_start    = eng_start_q;
   assign eng_cr       = eng_cr_q;
   assign eng_ci       = eng_ci_q;
   assign eng_max_iter = max_iter_q;
   assign wr_valid     = wr_valid_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// Directed bench for mandelbrot_frame_scheduler on a 4x2 frame with two modelled engines.
// Engine model returns (dispatch order within frame)+1, so data==addr+1 proves tags follow pixels.
// Inputs are driven 1 time unit after posedge; DUT outputs are observed on negedge.
module tb_mandelbrot_frame_scheduler;
   localparam int N  = 2;
   localparam int XR = 4;
   localparam int YR = 2;
   localparam int AW = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [26:0]       cr_start = '0, ci_start = '0, dx = '0, dy = '0;
   logic [15:0]       max_iterations = '0;
   logic [N-1:0]      eng_start;
   logic [27*N-1:0]   eng_cr, eng_ci;
   logic [15:0]       eng_max_iter;
   logic [N-1:0]      eng_done = '0;
   logic [16*N-1:0]   eng_iterations = '0;
   logic              wr_valid;
   logic [AW-1:0]     wr_addr;
   logic [15:0]       wr_data;
   logic              wr_ready = 1'b1;
   logic              busy, frame_done;
   logic [31:0]       frame_cycles;

   int checks = 0;
   int errors = 0;

   mandelbrot_frame_scheduler #(.NUM_ENGINES(N), .X_RES(XR), .Y_RES(YR), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cr_start(cr_start), .ci_start(ci_start), .dx(dx), .dy(dy),
      .max_iterations(max_iterations),
      .eng_start(eng_start), .eng_cr(eng_cr), .eng_ci(eng_ci), .eng_max_iter(eng_max_iter),
      .eng_done(eng_done), .eng_iterations(eng_iterations),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .frame_done(frame_done), .frame_cycles(frame_cycles)
   );

   always #5 clk = ~clk;

   // engine model: done drops on launch, rises lat cycles later, result = pixel order + 1
   int lat [N] = '{5, 5};
   int cnt [N] = '{0, 0};
   int eng_pix = 0;
   int frame_base = 0;
   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (eng_start[k]) begin
            eng_done[k]               <= 1'b0;
            cnt[k]                    <= lat[k];
            eng_iterations[16*k +: 16] <= 16'(eng_pix - frame_base + 1);
         end else if (cnt[k] > 0) begin
            cnt[k] <= cnt[k] - 1;
            if (cnt[k] == 1) eng_done[k] <= 1'b1;
         end
      end
      if (|eng_start) eng_pix <= eng_pix + 1;
   end

   // monitor: logs dispatch operands, accepted writes, frame_done pulses, overlap events
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic signed [26:0] d_cr [1024];
   logic signed [26:0] d_ci [1024];
   int disp_n = 0;
   int w_addr [1024];
   int w_data [1024];
   int w_cyc  [1024];
   int wr_n = 0;
   int fd_cnt = 0;
   int sim_cnt = 0;
   bit acc_prev = 1'b0;
   always @(negedge clk) begin
      if (|eng_start) begin
         for (int k = 0; k < N; k++) begin
            if (eng_start[k]) begin
               d_cr[disp_n] <= $signed(eng_cr[27*k +: 27]);
               d_ci[disp_n] <= $signed(eng_ci[27*k +: 27]);
            end
         end
         disp_n <= disp_n + 1;
         if (acc_prev) sim_cnt <= sim_cnt + 1;
      end
      acc_prev <= wr_valid && wr_ready;
      if (wr_valid && wr_ready) begin
         w_addr[wr_n] <= int'(wr_addr);
         w_data[wr_n] <= int'(wr_data);
         w_cyc[wr_n]  <= cyc;
         wr_n         <= wr_n + 1;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
   end

   logic signed [26:0] exp_cr [4] = '{-27'sd16777216, -27'sd8388608, 27'sd0, 27'sd8388608};
   logic signed [26:0] exp_ci [2] = '{27'sd8388608, 27'sd0};

   int st_cyc, d0, w0, fd0, sim0;

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_coords(input logic [26:0] cr, input logic [26:0] ci,
                             input logic [26:0] sx, input logic [26:0] sy);
      cr_start = cr; ci_start = ci; dx = sx; dy = sy;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start  = 1'b1;
      st_cyc = cyc;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic begin_frame();
      frame_base = eng_pix;
      d0   = disp_n;
      w0   = wr_n;
      fd0  = fd_cnt;
      sim0 = sim_cnt;
      pulse_start();
   endtask

   task automatic wait_frame_done();
      bit seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL frame_done_timeout: got no frame_done, required one within 1000 cycles");
      end
   endtask

   // number of anomalies in the 8 writes logged from index base: bad address, bad data, duplicates, losses
   function automatic int frame_bad(input int base);
      int seen [8] = '{default: 0};
      int bad = 0;
      int a;
      for (int i = 0; i < 8; i++) begin
         a = w_addr[base + i];
         if (a < 0 || a > 7) bad++;
         else seen[a]++;
         if (w_data[base + i] != a + 1) bad++;
      end
      for (int j = 0; j < 8; j++) if (seen[j] != 1) bad++;
      return bad;
   endfunction

   task automatic test_reset();
      int wsave;
      reset = 1'b0;
      wait_cycles(3);
      @(negedge clk);
      checks++;
      if ({busy, wr_valid, eng_start, frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b wr_valid=%b eng_start=%b frame_done=%b, required all 0",
                  busy, wr_valid, eng_start, frame_done);
      end
      checks++;
      if ({eng_cr, eng_ci} !== '0) begin
         errors++;
         $display("FAIL reset_operands: got cr=%h ci=%h, required 0", eng_cr, eng_ci);
      end
      checks++;
      if ({wr_addr, wr_data, frame_cycles, eng_max_iter} !== '0) begin
         errors++;
         $display("FAIL reset_data: got addr=%0d data=%0d cycles=%0d max=%0d, required 0",
                  wr_addr, wr_data, frame_cycles, eng_max_iter);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      // start a frame, then abandon it with a 3-cycle reset
      lat = '{5, 5};
      set_coords(-27'sd16777216, 27'sd8388608, 27'sd8388608, 27'sd8388608);
      max_iterations = 16'd100;
      begin_frame();
      wait_cycles(7);
      reset = 1'b0;
      wait_cycles(3);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, wr_valid, eng_start} !== '0) begin
         errors++;
         $display("FAIL reset_midframe: got busy=%b wr_valid=%b eng_start=%b, required 0",
                  busy, wr_valid, eng_start);
      end
      wsave = wr_n;
      wait_cycles(25);
      checks++;
      if (wr_n !== wsave || eng_done === '0) begin
         errors++;
         $display("FAIL reset_late_done: got %0d writes with eng_done=%b, required 0 writes with done raised",
                  wr_n - wsave, eng_done);
      end
   endtask

   task automatic test_basic();
      int bad;
      lat = '{5, 5};
      wr_ready = 1'b1;
      set_coords(-27'sd16777216, 27'sd8388608, 27'sd8388608, 27'sd8388608);
      max_iterations = 16'd100;
      begin_frame();
      wait_frame_done();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_in_done: got %b, required 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_fall: got busy=%b frame_done=%b, required 0 0", busy, frame_done);
      end
      wait_cycles(3);
      for (int p = 0; p < 8; p++) begin
         checks++;
         if (d_cr[d0 + p] !== exp_cr[p % 4]) begin
            errors++;
            $display("FAIL basic_cr[%0d]: got %0d, required %0d", p, d_cr[d0 + p], exp_cr[p % 4]);
         end
         checks++;
         if (d_ci[d0 + p] !== exp_ci[p / 4]) begin
            errors++;
            $display("FAIL basic_ci[%0d]: got %0d, required %0d", p, d_ci[d0 + p], exp_ci[p / 4]);
         end
      end
      checks++;
      if (wr_n - w0 !== 8 || disp_n - d0 !== 8) begin
         errors++;
         $display("FAIL basic_counts: got %0d writes %0d dispatches, required 8 8", wr_n - w0, disp_n - d0);
      end
      bad = frame_bad(w0);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL basic_writes: got %0d anomalies, required 0", bad);
      end
      checks++;
      if (fd_cnt - fd0 !== 1) begin
         errors++;
         $display("FAIL basic_frame_done_count: got %0d, required 1", fd_cnt - fd0);
      end
      checks++;
      if (eng_max_iter !== 16'd100) begin
         errors++;
         $display("FAIL basic_max_iter: got %0d, required 100", eng_max_iter);
      end
      checks++;
      if (frame_cycles !== 32'(w_cyc[w0 + 7] - st_cyc + 1)) begin
         errors++;
         $display("FAIL basic_frame_cycles: got %0d, required %0d", frame_cycles, w_cyc[w0 + 7] - st_cyc + 1);
      end
   endtask

   task automatic test_out_of_order();
      int bad, pos0, pos1;
      lat = '{20, 2};
      begin_frame();
      wait_frame_done();
      wait_cycles(3);
      pos0 = -1; pos1 = -1;
      for (int i = 0; i < 8; i++) begin
         if (w_addr[w0 + i] == 0) pos0 = i;
         if (w_addr[w0 + i] == 1) pos1 = i;
      end
      checks++;
      if (w_addr[w0] !== 1) begin
         errors++;
         $display("FAIL ooo_first_addr: got %0d, required 1", w_addr[w0]);
      end
      checks++;
      if (!(pos1 >= 0 && pos0 > pos1)) begin
         errors++;
         $display("FAIL ooo_order: got addr0 at %0d addr1 at %0d, required addr1 first", pos0, pos1);
      end
      bad = frame_bad(w0);
      checks++;
      if (bad !== 0 || wr_n - w0 !== 8) begin
         errors++;
         $display("FAIL ooo_writes: got %0d anomalies %0d writes, required 0 and 8", bad, wr_n - w0);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      lat = '{5, 5};
      wr_ready = 1'b0;
      begin_frame();
      wait_cycles(14);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if ({wr_valid, wr_addr, wr_data, eng_start} !== {1'b1, 3'd0, 16'd1, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b addr=%0d data=%0d eng_start=%b, required 1 0 1 00",
                     i, wr_valid, wr_addr, wr_data, eng_start);
         end
      end
      wait_cycles(1);
      wr_ready = 1'b1;
      wait_frame_done();
      wait_cycles(3);
      bad = frame_bad(w0);
      checks++;
      if (bad !== 0 || wr_n - w0 !== 8) begin
         errors++;
         $display("FAIL bp_writes: got %0d anomalies %0d writes, required 0 and 8", bad, wr_n - w0);
      end
      checks++;
      if (frame_cycles !== 32'(w_cyc[w0 + 7] - st_cyc + 1)) begin
         errors++;
         $display("FAIL bp_frame_cycles: got %0d, required %0d", frame_cycles, w_cyc[w0 + 7] - st_cyc + 1);
      end
   endtask

   task automatic test_start_while_busy();
      int bad;
      lat = '{5, 5};
      set_coords(-27'sd16777216, 27'sd8388608, 27'sd8388608, 27'sd8388608);
      begin_frame();
      wait_cycles(5);
      // coordinates that would be visible if the second start reloaded them
      set_coords(27'sd67108863, -27'sd67108864, 27'sd1, 27'sd1);
      pulse_start();
      wait_frame_done();
      wait_cycles(3);
      for (int p = 0; p < 8; p++) begin
         checks++;
         if (d_cr[d0 + p] !== exp_cr[p % 4] || d_ci[d0 + p] !== exp_ci[p / 4]) begin
            errors++;
            $display("FAIL busy_start_coord[%0d]: got cr=%0d ci=%0d, required cr=%0d ci=%0d",
                     p, d_cr[d0 + p], d_ci[d0 + p], exp_cr[p % 4], exp_ci[p / 4]);
         end
      end
      bad = frame_bad(w0);
      checks++;
      if (bad !== 0 || wr_n - w0 !== 8 || fd_cnt - fd0 !== 1) begin
         errors++;
         $display("FAIL busy_start_frame: got %0d anomalies %0d writes %0d done pulses, required 0 8 1",
                  bad, wr_n - w0, fd_cnt - fd0);
      end
      // new frame from IDLE with the extreme coordinates: exercises 27-bit wrap
      begin_frame();
      wait_frame_done();
      wait_cycles(3);
      checks++;
      if (d_cr[d0] !== 27'sd67108863 || d_ci[d0] !== -27'sd67108864) begin
         errors++;
         $display("FAIL wrap_p0: got cr=%0d ci=%0d, required 67108863 -67108864", d_cr[d0], d_ci[d0]);
      end
      checks++;
      if (d_cr[d0 + 1] !== -27'sd67108864) begin
         errors++;
         $display("FAIL wrap_cr_p1: got %0d, required -67108864", d_cr[d0 + 1]);
      end
      checks++;
      if (d_cr[d0 + 3] !== -27'sd67108862) begin
         errors++;
         $display("FAIL wrap_cr_p3: got %0d, required -67108862", d_cr[d0 + 3]);
      end
      checks++;
      if (d_cr[d0 + 4] !== 27'sd67108863 || d_ci[d0 + 4] !== 27'sd67108863) begin
         errors++;
         $display("FAIL wrap_p4: got cr=%0d ci=%0d, required 67108863 67108863", d_cr[d0 + 4], d_ci[d0 + 4]);
      end
      bad = frame_bad(w0);
      checks++;
      if (bad !== 0 || wr_n - w0 !== 8) begin
         errors++;
         $display("FAIL wrap_writes: got %0d anomalies %0d writes, required 0 and 8", bad, wr_n - w0);
      end
   endtask

   task automatic test_simultaneous();
      int bad;
      lat = '{3, 3};
      wr_ready = 1'b0;
      set_coords(-27'sd16777216, 27'sd8388608, 27'sd8388608, 27'sd8388608);
      begin_frame();
      wait_cycles(18);
      wr_ready = 1'b1;
      wait_frame_done();
      wait_cycles(3);
      checks++;
      if (sim_cnt - sim0 < 1) begin
         errors++;
         $display("FAIL sim_overlap: got %0d accept+dispatch cycles, required at least 1", sim_cnt - sim0);
      end
      bad = frame_bad(w0);
      checks++;
      if (bad !== 0 || wr_n - w0 !== 8) begin
         errors++;
         $display("FAIL sim_writes: got %0d anomalies %0d writes, required 0 and 8", bad, wr_n - w0);
      end
      checks++;
      if (frame_cycles !== 32'(w_cyc[w0 + 7] - st_cyc + 1)) begin
         errors++;
         $display("FAIL sim_frame_cycles: got %0d, required %0d", frame_cycles, w_cyc[w0 + 7] - st_cyc + 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_out_of_order();
      test_backpressure();
      test_start_while_busy();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mandelbrot_frame_scheduler.md
Name: mandelbrot_frame_scheduler

Overview:
- Sequences one full Mandelbrot frame across NUM_ENGINES instances of mandelbrot_iterate.
- Sweeps pixel coordinates, computes cr/ci in 4.23 fixed point and dispatches each pixel to a free engine.
- Collects iteration counts, possibly out of order, and writes them to the pixel buffer with a tagged address.
- Sits between the HPS-side configuration registers and the iterator array / VGA frame memory.

Parameters:
- NUM_ENGINES, 4, number of iterator instances; 1..16.
- X_RES, 640, pixels per row.
- Y_RES, 480, rows per frame.
- ADDR_W, 19, pixel-address width; must satisfy 2^ADDR_W >= X_RES*Y_RES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- cr_start  in  27  signed 4.23 real coordinate of pixel (0,0).
- ci_start  in  27  signed 4.23 imaginary coordinate of pixel (0,0).
- dx  in  27  signed 4.23 real step per column.
- dy  in  27  signed 4.23 imaginary step per row; subtracted.
- max_iterations  in  16  iteration cap, forwarded to the engines.
- eng_start  out  NUM_ENGINES  per-engine one-cycle launch pulse.
- eng_cr  out  27*NUM_ENGINES  packed cr; engine k uses bits [27k+26:27k].
- eng_ci  out  27*NUM_ENGINES  packed ci, same packing.
- eng_max_iter  out  16  registered copy of max_iterations.
- eng_done  in  NUM_ENGINES  level; high from result-valid until the next eng_start.
- eng_iterations  in  16*NUM_ENGINES  packed results, valid while eng_done.
- wr_valid  out  1  pixel write request.
- wr_addr  out  ADDR_W  pixel index, y*X_RES+x.
- wr_data  out  16  iteration count.
- wr_ready  in  1  write accepted when wr_valid && wr_ready.
- busy  out  1  high from the start-accept cycle through DONE.
- frame_done  out  1  one-cycle pulse when the last pixel is written.
- frame_cycles  out  32  clk count of the last completed frame.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All eng_start, wr_valid, busy and frame_done are 0. eng_cr, eng_ci, wr_addr, wr_data, frame_cycles and eng_max_iter are 0. All engine slots are FREE. Reset mid-frame abandons the frame; late eng_done is ignored because every slot is FREE.
- States: IDLE -> RUN on start. RUN -> DRAIN when the last pixel is dispatched. DRAIN -> DONE when all slots are FREE. DONE -> IDLE after 1 cycle, with frame_done=1 in that cycle. start outside IDLE is ignored.
- Start accept: latch cr_start, ci_start, dx, dy and max_iterations. Set x=y=0, cur_cr=cr_start, cur_ci=ci_start, cycle counter=0.
- Slot states: FREE, BUSY and READY. BUSY->READY happens when eng_done is seen high while BUSY and eng_start is not pulsing.
- Dispatch (RUN only): at most one pixel per cycle, to the lowest-index FREE slot. That cycle drives eng_start[k]=1 and registers eng_cr[k]/eng_ci[k] in the same cycle (registered outputs; pulse and operands update together). It also stores the tag addr[k]=y*X_RES+x (running counter, no multiplier). Slot goes BUSY.
- Coordinate advance: x++ and cur_cr+=dx. At x==X_RES-1: x=0, y++, cur_cr=cr_start, cur_ci-=dy. Arithmetic is 27-bit two's complement with wrap and no saturation.
- Collection: round-robin over READY slots, with the pointer starting after the last granted slot. The winner drives wr_valid=1, wr_addr=tag and wr_data=eng_iterations[k]. These are held stable until wr_ready; the slot then goes FREE.
- Pipelining: the next write may be presented the cycle after acceptance. A slot freed by write acceptance is dispatchable the next cycle.
- Simultaneous events: dispatch and collection are independent and may both occur in one cycle.
- Backpressure: wr_ready low stalls collection only. Dispatch stops naturally once all slots are BUSY or READY.
- frame_cycles is updated in DONE with the cycles from start accept to the last write acceptance inclusive.
- Every pixel address is written exactly once per frame.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-frame -> next cycle busy=0, wr_valid=0, eng_start=0. A later eng_done=1 produces no write, and the frame restarts cleanly on start.
- Basic frame (X_RES=4, Y_RES=2, NUM_ENGINES=2, engine model returns iterations=addr+1 after 5 cycles; cr_start=-16777216, ci_start=8388608, dx=8388608, dy=8388608). Required response:
  - cr sequence -16777216, -8388608, 0, 8388608 per row.
  - ci = 8388608 for row 0 and 0 for row 1.
  - 8 writes with addresses {0..7}, each once, data=addr+1.
  - frame_done pulses once, and busy falls the cycle after it.
- Out-of-order: engine 1 latency 2 and engine 0 latency 20 -> addr 1 is written before addr 0. Tags are correct, with no duplicates or losses.
- Backpressure: wr_ready=0 for 30 cycles mid-frame -> wr_valid/wr_addr/wr_data stay stable and no eng_start occurs once both slots are non-FREE. Releasing wr_ready resumes and all 8 pixels complete.
- Start while busy: second start pulse during RUN -> ignored, with no coordinate reload and the frame completing normally. A start in IDLE then begins a new frame.
- Simultaneous: a write acceptance and a dispatch to another FREE slot happen in the same cycle -> both take effect, and frame_cycles equals the bench-measured count.
